dpb_master_rd: RTL

DPB_MASTER_RD -- requirements
Module: dpb_master_rd

---
 rtl/dpb_master_rd.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/dpb_master_rd.sv
// DPB port-B reader: streams one slot (32-bit header + N 128-bit words) as a UDP byte packet.
// Optional header rank / word-count checking is enabled by defining DPB_RD_HDR_CHECK_EN.
module dpb_master_rd #(
    parameter logic [6:0]  UDP_FRAME_MAX_SIZE_128 = 7'd91,
    parameter int unsigned RD_LATENCY             = 2
) (
    input  logic         i_pclk,
    input  logic         i_rst_n,
    input  logic         i_wr_req,
    input  logic         i_wr_frame_down,
    input  logic [3:0]   i_wr_buf_rank,
    input  logic [6:0]   i_wr_buf_128cnt,
    input  logic [5:0]   i_wr_buf_Bytecnt,
    output logic [10:0]  o_dpb_rd_b_addr,
    output logic         o_dpb_rd_b_cea,
    output logic         o_dpb_rd_b_ocea,
    input  logic [127:0] i_dpb_rd_b_rd_data,
    output logic         o_udp_tx_req,
    output logic [15:0]  o_udp_tx_len,
    input  logic         i_udp_tx_ready,
    output logic         o_udp_tx_de,
    output logic [7:0]   o_udp_tx_data,
    output logic         o_udp_tx_last,
    output logic         o_rd_down,
    output logic         o_frame_end,
    output logic         o_error
);

    typedef enum logic [2:0] {StIdle, StHeadRd, StTxReq, StStream, StDone} state_t;

    localparam logic [1:0] LatLast    = 2'(RD_LATENCY);
    // Next word address goes out so its data is valid on the current word's final byte.
    localparam logic [4:0] PrefetchAt = 5'(RD_LATENCY + 2);

    state_t         state_q, state_d;
    logic           pend_vld_q, pend_vld_d;
    logic [3:0]     pend_rank_q;
    logic [6:0]     pend_n_q;
    logic [5:0]     pend_b_q;
    logic           pend_fd_q;
    logic [3:0]     rank_q, rank_d;
    logic [6:0]     n_q, n_d;
    logic [4:0]     blen_q, blen_d;
    logic           fd_q, fd_d;
    logic [1:0]     lat_cnt_q, lat_cnt_d;
    logic [127:0]   word_q, word_d;
    logic [4:0]     left_q, left_d;
    logic [6:0]     widx_q, widx_d;
    logic [10:0]    addr_q, addr_d;
    logic [15:0]    len_q, len_d;
    logic           err_q, err_d;

    logic           consume, pend_free, n_ok, accept, head_done, hdr_err;
    logic [4:0]     pend_blen;
    logic [15:0]    pend_len;

    assign consume   = (state_q == StIdle) && pend_vld_q;
    assign pend_free = !pend_vld_q || consume;
    assign n_ok      = (i_wr_buf_128cnt != 7'd0) && (i_wr_buf_128cnt <= UDP_FRAME_MAX_SIZE_128);
    assign accept    = i_wr_req && n_ok && pend_free;
    assign head_done = (state_q == StHeadRd) && (lat_cnt_q == LatLast);
    assign pend_blen = ((pend_b_q == 6'd0) || (pend_b_q > 6'd16)) ? 5'd16 : pend_b_q[4:0];
    assign pend_len  = 16'd4 + (({9'd0, pend_n_q} - 16'd1) << 4) + {11'd0, pend_blen};

    always_comb begin
        pend_vld_d = pend_vld_q;
        if (accept) begin
            pend_vld_d = 1'b1;
        end else if (consume) begin
            pend_vld_d = 1'b0;
        end
        err_d = err_q | (i_wr_req && !(n_ok && pend_free)) | hdr_err;
    end

`ifdef DPB_RD_HDR_CHECK_EN
    logic [7:0]  exp_rank_q, exp_rank_d;
    logic [31:0] hdr;

    // Header layout: byte1 = udp rank, byte3 = payload word count.
    always_comb begin
        hdr        = i_dpb_rd_b_rd_data[127:96];
        hdr_err    = 1'b0;
        exp_rank_d = exp_rank_q;
        if (head_done) begin
            hdr_err    = (hdr[23:16] != exp_rank_q) || (hdr[7:0] != {1'b0, n_q});
            exp_rank_d = fd_q ? 8'd1 : exp_rank_q + 8'd1;
        end
    end

    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            exp_rank_q <= 8'd1;
        end else begin
            exp_rank_q <= exp_rank_d;
        end
    end
`else
    assign hdr_err = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        rank_d    = rank_q;
        n_d       = n_q;
        blen_d    = blen_q;
        fd_d      = fd_q;
        lat_cnt_d = lat_cnt_q;
        word_d    = word_q;
        left_d    = left_q;
        widx_d    = widx_q;
        addr_d    = addr_q;
        len_d     = len_q;
        unique case (state_q)
            StIdle: begin
                if (pend_vld_q) begin
                    rank_d    = pend_rank_q;
                    n_d       = pend_n_q;
                    blen_d    = pend_blen;
                    fd_d      = pend_fd_q;
                    len_d     = pend_len;
                    addr_d    = {pend_rank_q, 7'd0};
                    lat_cnt_d = 2'd0;
                    state_d   = StHeadRd;
                end
            end
            StHeadRd: begin
                if (lat_cnt_q == LatLast) begin
                    word_d  = {i_dpb_rd_b_rd_data[127:96], 96'd0};
                    left_d  = 5'd4;
                    widx_d  = 7'd0;
                    addr_d  = {rank_q, 7'd1};
                    state_d = StTxReq;
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                end
            end
            StTxReq: begin
                if (i_udp_tx_ready) begin
                    state_d = StStream;
                end
            end
            StStream: begin
                if ((widx_q != 7'd0) && (widx_q != n_q) && (left_q == PrefetchAt)) begin
                    addr_d = {rank_q, addr_q[6:0] + 7'd1};
                end
                if (left_q == 5'd1) begin
                    if (widx_q == n_q) begin
                        state_d = StDone;
                    end else begin
                        word_d = i_dpb_rd_b_rd_data;
                        widx_d = widx_q + 7'd1;
                        left_d = ((widx_q + 7'd1) == n_q) ? blen_q : 5'd16;
                    end
                end else begin
                    word_d = word_q << 8;
                    left_d = left_q - 5'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend_vld_q  <= 1'b0;
            pend_rank_q <= 4'd0;
            pend_n_q    <= 7'd0;
            pend_b_q    <= 6'd0;
            pend_fd_q   <= 1'b0;
            rank_q      <= 4'd0;
            n_q         <= 7'd0;
            blen_q      <= 5'd0;
            fd_q        <= 1'b0;
            lat_cnt_q   <= 2'd0;
            word_q      <= 128'd0;
            left_q      <= 5'd0;
            widx_q      <= 7'd0;
            addr_q      <= 11'd0;
            len_q       <= 16'd0;
            err_q       <= 1'b0;
        end else begin
            pend_vld_q <= pend_vld_d;
            if (accept) begin
                pend_rank_q <= i_wr_buf_rank;
                pend_n_q    <= i_wr_buf_128cnt;
                pend_b_q    <= i_wr_buf_Bytecnt;
                pend_fd_q   <= i_wr_frame_down;
            end
            rank_q    <= rank_d;
            n_q       <= n_d;
            blen_q    <= blen_d;
            fd_q      <= fd_d;
            lat_cnt_q <= lat_cnt_d;
            word_q    <= word_d;
            left_q    <= left_d;
            widx_q    <= widx_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            err_q     <= err_d;
        end
    end

    assign o_dpb_rd_b_addr = addr_q;
    assign o_dpb_rd_b_cea  = 1'b1;
    assign o_dpb_rd_b_ocea = 1'b1;
    assign o_udp_tx_req    = (state_q == StTxReq);
    assign o_udp_tx_len    = len_q;
    assign o_udp_tx_de     = (state_q == StStream);
    assign o_udp_tx_data   = o_udp_tx_de ? word_q[127:120] : 8'd0;
    assign o_udp_tx_last   = o_udp_tx_de && (left_q == 5'd1) && (widx_q == n_q);
    assign o_rd_down       = (state_q == StDone);
    assign o_frame_end     = (state_q == StDone) && fd_q;
    assign o_error         = err_q;

endmodule
